// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU coprocessor: instruction encoding and the
// writeback queue entry.
package fir_xifu_pkg;

    localparam int unsigned WB_DEPTH_DEFAULT    = 4;
    localparam int unsigned WB_ID_WIDTH_DEFAULT = 4;
    // Entry id field is sized for the widest supported ID space; narrower
    // configurations use the low bits only.
    localparam int unsigned WB_ID_MAX_W         = 8;

    typedef enum logic [1:0] {
        XIFU_NONE     = 2'd0,
        XIFU_XFIRLW   = 2'd1,
        XIFU_XFIRSW   = 2'd2,
        XIFU_XFIRDOTP = 2'd3
    } fir_xifu_instr_e;

    typedef struct packed {
        fir_xifu_instr_e        instr;
        logic [WB_ID_MAX_W-1:0] id;
        logic [4:0]             rd;
        logic [4:0]             rs1;
        logic [31:0]            result;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

    function automatic logic is_mem_instr(input fir_xifu_instr_e instr);
        return (instr == XIFU_XFIRLW) || (instr == XIFU_XFIRSW);
    endfunction

endpackage

// File: rtl/fir_xifu_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push on full and pop on empty
// are ignored. Read data is the current head (show-ahead).
module fir_xifu_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fir_xifu_wb_q.sv
// Queued writeback for the FIR XIFU: buffers EX2 entries and load data,
// retires committed entries in order onto the X-interface result channel.
module fir_xifu_wb_q
    import fir_xifu_pkg::*;
#(
    parameter  int unsigned DEPTH    = WB_DEPTH_DEFAULT,
    parameter  int unsigned ID_WIDTH = WB_ID_WIDTH_DEFAULT,
    localparam int unsigned NUM_IDS  = 2 ** ID_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ex2wb_valid_i,
    output logic                ex2wb_ready_o,
    input  fir_xifu_instr_e     ex2wb_instr_i,
    input  logic [ID_WIDTH-1:0] ex2wb_id_i,
    input  logic [4:0]          ex2wb_rd_i,
    input  logic [4:0]          ex2wb_rs1_i,
    input  logic [31:0]         ex2wb_result_i,
    input  logic                mem_result_valid_i,
    input  logic [31:0]         mem_result_rdata_i,
    input  logic [NUM_IDS-1:0]  commit_i,
    input  logic [NUM_IDS-1:0]  kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [31:0]         result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                rf_write_o,
    output logic [4:0]          rf_rd_o,
    output logic [31:0]         rf_result_o,
    output logic [NUM_IDS-1:0]  clear_o,
    output logic                kill_o,
    output logic                err_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t           enq_entry;
    wb_entry_t           head;
    logic                q_push;
    logic                q_pop;
    logic                q_full;
    logic                q_empty;

    logic [31:0]         rd_head;
    logic                rd_push;
    logic                rd_pop;
    logic                rd_full;
    logic                rd_empty;

    logic [CW-1:0]       outstanding_q;
    logic                err_q;

    logic [ID_WIDTH-1:0] head_id;
    logic                head_id_unused;
    logic                head_mem;
    logic                head_kill;
    logic                head_commit;
    logic                mem_accept;
    logic                data_avail;
    logic                retire;
    logic                bypass;
    logic                enq_mem;
    logic                kill_mem;
    logic [31:0]         rdata_sel;

    // Enqueue side: NONE never occupies a slot.
    assign ex2wb_ready_o = !q_full;
    assign q_push        = ex2wb_valid_i && !q_full && (ex2wb_instr_i != XIFU_NONE);
    assign enq_mem       = q_push && is_mem_instr(ex2wb_instr_i);

    always_comb begin
        enq_entry        = '0;
        enq_entry.instr  = ex2wb_instr_i;
        enq_entry.id     = WB_ID_MAX_W'(ex2wb_id_i);
        enq_entry.rd     = ex2wb_rd_i;
        enq_entry.rs1    = ex2wb_rs1_i;
        enq_entry.result = ex2wb_result_i;
    end

    fir_xifu_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (q_push),
        .wdata_i (enq_entry),
        .pop_i   (q_pop),
        .rdata_o (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Load data FIFO: results are only accepted against an outstanding load,
    // and a result that is consumed by the head in its arrival cycle skips it.
    assign mem_accept = mem_result_valid_i && (outstanding_q != '0);
    assign rd_push    = mem_accept && !bypass;
    assign rd_pop     = retire && head_mem && !rd_empty;

    fir_xifu_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_rdata_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rd_push),
        .wdata_i (mem_result_rdata_i),
        .pop_i   (rd_pop),
        .rdata_o (rd_head),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    // Head decision: kill beats commit, and nothing leaves during reset.
    assign head_id        = head.id[ID_WIDTH-1:0];
    assign head_id_unused = ^{head.id, rd_full};
    assign head_mem       = is_mem_instr(head.instr);
    assign head_kill      = !rst_i && !q_empty && kill_i[head_id];
    assign head_commit    = !rst_i && !q_empty && commit_i[head_id];
    assign data_avail     = !head_mem || !rd_empty || mem_accept;

    assign result_valid_o = head_commit && !head_kill && data_avail;
    assign retire         = result_valid_o && result_ready_i;
    assign bypass         = retire && head_mem && rd_empty;
    assign q_pop          = retire || head_kill;
    assign kill_mem       = head_kill && head_mem;
    assign rdata_sel      = rd_empty ? mem_result_rdata_i : rd_head;

    assign result_we_o    = result_valid_o;
    assign result_id_o    = result_valid_o ? head_id    : '0;
    assign result_data_o  = result_valid_o ? head.result : '0;
    assign result_rd_o    = result_valid_o ? head.rs1   : '0;

    assign rf_write_o     = retire && (head.instr != XIFU_XFIRSW);
    assign rf_rd_o        = rf_write_o ? head.rd : '0;
    assign rf_result_o    = !rf_write_o                  ? '0 :
                            (head.instr == XIFU_XFIRLW) ? rdata_sel : head.result;

    assign kill_o         = head_kill;
    assign clear_o        = q_pop ? (NUM_IDS'(1) << head_id) : '0;
    assign err_o          = err_q;

    // A killed memory entry never receives data, so it leaves the count here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_q + CW'(enq_mem) - CW'(mem_accept) - CW'(kill_mem);
            if (mem_result_valid_i && (outstanding_q == '0)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_xifu_wb_q.sv
// Scoreboard bench for fir_xifu_wb_q: directed scenarios plus randomized
// traffic against an in-order retirement model.
`timescale 1ns/1ps
module tb_fir_xifu_wb_q;
    import fir_xifu_pkg::*;

    localparam int DEPTH    = 4;
    localparam int ID_WIDTH = 4;
    localparam int NUM_IDS  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                ex2wb_valid;
    logic                ex2wb_ready;
    fir_xifu_instr_e     ex2wb_instr;
    logic [ID_WIDTH-1:0] ex2wb_id;
    logic [4:0]          ex2wb_rd;
    logic [4:0]          ex2wb_rs1;
    logic [31:0]         ex2wb_result;
    logic                mem_valid;
    logic [31:0]         mem_data;
    logic [NUM_IDS-1:0]  commit_vec;
    logic [NUM_IDS-1:0]  kill_vec;
    logic                result_valid;
    logic                result_ready;
    logic [ID_WIDTH-1:0] result_id;
    logic [31:0]         result_data;
    logic [4:0]          result_rd;
    logic                result_we;
    logic                rf_write;
    logic [4:0]          rf_rd;
    logic [31:0]         rf_result;
    logic [NUM_IDS-1:0]  clear;
    logic                kill_p;
    logic                err;

    always #5 clk = ~clk;

    fir_xifu_wb_q #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .ex2wb_valid_i      (ex2wb_valid),
        .ex2wb_ready_o      (ex2wb_ready),
        .ex2wb_instr_i      (ex2wb_instr),
        .ex2wb_id_i         (ex2wb_id),
        .ex2wb_rd_i         (ex2wb_rd),
        .ex2wb_rs1_i        (ex2wb_rs1),
        .ex2wb_result_i     (ex2wb_result),
        .mem_result_valid_i (mem_valid),
        .mem_result_rdata_i (mem_data),
        .commit_i           (commit_vec),
        .kill_i             (kill_vec),
        .result_valid_o     (result_valid),
        .result_ready_i     (result_ready),
        .result_id_o        (result_id),
        .result_data_o      (result_data),
        .result_rd_o        (result_rd),
        .result_we_o        (result_we),
        .rf_write_o         (rf_write),
        .rf_rd_o            (rf_rd),
        .rf_result_o        (rf_result),
        .clear_o            (clear),
        .kill_o             (kill_p),
        .err_o              (err)
    );

    typedef struct {
        bit          kill;
        int unsigned id;
        logic [4:0]  rs1;
        logic [31:0] result;
        bit          rf_we;
        logic [4:0]  rd;
        logic [31:0] rf_data;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } mem_t;

    exp_t               exp_q[$];
    mem_t               mem_q[$];
    int                 total = 0;
    int                 bad   = 0;
    int                 cyc   = 0;
    bit                 done  = 1'b0;
    bit                 drain_to = 1'b0;
    bit                 err_exp = 1'b0;
    bit                 push_now = 1'b0;
    logic [NUM_IDS-1:0] inflight = '0;
    logic [NUM_IDS-1:0] pend_commit = '0;
    int                 commit_at [NUM_IDS];
    logic [NUM_IDS-1:0] clr_tgl = '0;
    logic [NUM_IDS-1:0] clr_ack = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: close the current cycle, then release the controller flags of
    // every ID the monitor saw cleared.
    task automatic step();
        logic [NUM_IDS-1:0] fresh;
        @(posedge clk);
        #1;
        cyc++;
        fresh       = clr_tgl ^ clr_ack;
        clr_ack     = clr_tgl;
        commit_vec  = commit_vec & ~fresh;
        kill_vec    = kill_vec & ~fresh;
        inflight    = inflight & ~fresh;
        pend_commit = pend_commit & ~fresh;
        ex2wb_valid = 1'b0;
        ex2wb_instr = XIFU_NONE;
        mem_valid   = 1'b0;
        push_now    = 1'b0;
    endtask

    task automatic enq(input fir_xifu_instr_e ins, input int unsigned id, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [31:0] res, input logic [31:0] rdata,
                       input bit kill);
        exp_t rec;
        ex2wb_valid  = 1'b1;
        ex2wb_instr  = ins;
        ex2wb_id     = ID_WIDTH'(id);
        ex2wb_rd     = rd;
        ex2wb_rs1    = rs1;
        ex2wb_result = res;
        push_now     = 1'b1;
        inflight[id] = 1'b1;
        if (kill) kill_vec[id] = 1'b1;
        rec.kill    = kill;
        rec.id      = id;
        rec.rs1     = rs1;
        rec.result  = res;
        rec.rf_we   = !kill && (ins != XIFU_XFIRSW);
        rec.rd      = rd;
        rec.rf_data = (ins == XIFU_XFIRLW) ? rdata : res;
        if (!kill && ins != XIFU_XFIRDOTP) mem_q.push_back('{rdata, cyc});
        exp_q.push_back(rec);
    endtask

    task automatic send_mem();
        if (mem_q.size() != 0 && mem_q[0].cyc < cyc) begin
            mem_valid = 1'b1;
            mem_data  = mem_q[0].data;
            void'(mem_q.pop_front());
        end
    endtask

    task automatic tick_ctrl();
        for (int i = 0; i < NUM_IDS; i++) begin
            if (pend_commit[i] && cyc >= commit_at[i]) begin
                commit_vec[i]  = 1'b1;
                pend_commit[i] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        result_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            tick_ctrl();
            send_mem();
            step();
            n++;
        end
        if (exp_q.size() != 0) drain_to = 1'b1;
    endtask

    // Monitor: checks the DUT against the head of the expected queue every cycle.
    initial begin
        exp_t e;
        bit   retire_exp;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            if (rst) begin
                chk("clear_in_reset", 32'(clear), 32'd0);
                continue;
            end
            chk("ex2wb_ready", 32'(ex2wb_ready), 32'((exp_q.size() - int'(push_now)) < DEPTH));
            chk("err", 32'(err), 32'(err_exp));
            if (exp_q.size() == 0) begin
                chk("idle_valid", 32'(result_valid), 32'd0);
                chk("idle_clear", 32'(clear), 32'd0);
                chk("idle_rf_write", 32'(rf_write), 32'd0);
                chk("idle_kill", 32'(kill_p), 32'd0);
            end else begin
                e = exp_q[0];
                retire_exp = result_valid && result_ready;
                if (result_valid) begin
                    chk("valid_on_killed", 32'(e.kill), 32'd0);
                    chk("result_id", 32'(result_id), e.id);
                    chk("result_data", result_data, e.result);
                    chk("result_rd", 32'(result_rd), 32'(e.rs1));
                    chk("result_we", 32'(result_we), 32'd1);
                end
                if (clear != '0 || retire_exp) begin
                    chk("clear", 32'(clear), 32'd1 << e.id);
                    chk("kill_pulse", 32'(kill_p), 32'(e.kill));
                    if (e.kill) begin
                        chk("kill_no_valid", 32'(result_valid), 32'd0);
                        chk("kill_no_rf", 32'(rf_write), 32'd0);
                    end else begin
                        chk("rf_write", 32'(rf_write), 32'(e.rf_we));
                        if (e.rf_we) begin
                            chk("rf_rd", 32'(rf_rd), 32'(e.rd));
                            chk("rf_result", rf_result, e.rf_data);
                        end
                    end
                    clr_tgl = clr_tgl ^ clear;
                    void'(exp_q.pop_front());
                end else begin
                    chk("stray_kill", 32'(kill_p), 32'd0);
                    chk("stray_rf_write", 32'(rf_write), 32'd0);
                end
            end
        end
        chk("drain_timeout", 32'(drain_to), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        int unsigned id;
        int          r;
        fir_xifu_instr_e ins;
        rst = 1'b1; ex2wb_valid = 1'b0; ex2wb_instr = XIFU_NONE; ex2wb_id = '0;
        ex2wb_rd = '0; ex2wb_rs1 = '0; ex2wb_result = '0; mem_valid = 1'b0; mem_data = '0;
        commit_vec = '0; kill_vec = '0; result_ready = 1'b1;
        for (int i = 0; i < NUM_IDS; i++) commit_at[i] = 0;
        step(); step();
        rst = 1'b0;
        step();

        // Single DOTP, committed two cycles after enqueue.
        enq(XIFU_XFIRDOTP, 3, 5'd7, 5'd9, 32'h1234, 32'h0, 1'b0);
        step(); step();
        commit_vec[3] = 1'b1;
        step(); step();

        // Four loads fill the queue; data arrives first, result channel stalls.
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq(XIFU_XFIRLW, 8 + i, 5'(i + 1), 5'(i + 10), 32'h100 + i, 32'hA + i, 1'b0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            send_mem();
            step();
        end
        for (int i = 0; i < 4; i++) commit_vec[8 + i] = 1'b1;
        repeat (3) step();
        drain();

        // Load whose data, commit and ready coincide.
        enq(XIFU_XFIRLW, 2, 5'd4, 5'd5, 32'h20, 32'hBEEF, 1'b0);
        step();
        commit_vec[2] = 1'b1;
        send_mem();
        step();
        drain();

        // Store killed while also committed.
        enq(XIFU_XFIRSW, 5, 5'd1, 5'd2, 32'h44, 32'h0, 1'b1);
        commit_vec[5] = 1'b1;
        step();
        drain();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            result_ready = ($urandom_range(0, 9) < 7);
            tick_ctrl();
            if ($urandom_range(0, 2) != 0) send_mem();
            if (ex2wb_ready && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 9) == 0) begin
                    ex2wb_valid = 1'b1;
                    ex2wb_instr = XIFU_NONE;
                    ex2wb_id    = ID_WIDTH'($urandom_range(0, NUM_IDS - 1));
                end else begin
                    id = $urandom_range(0, NUM_IDS - 1);
                    while (inflight[id]) id = (id + 1) % NUM_IDS;
                    ins = fir_xifu_instr_e'($urandom_range(1, 3));
                    r = $urandom_range(0, 5);
                    enq(ins, id, 5'($urandom), 5'($urandom), $urandom, $urandom, r == 0);
                    if (r == 0) begin
                        if ($urandom_range(0, 1) == 1) commit_vec[id] = 1'b1;
                    end else begin
                        pend_commit[id] = 1'b1;
                        commit_at[id]   = cyc + $urandom_range(0, 3);
                    end
                end
            end
            step();
        end
        drain();

        // Memory result with nothing outstanding.
        mem_valid = 1'b1;
        mem_data  = 32'hDEAD_0001;
        step();
        err_exp = 1'b1;
        repeat (3) step();

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            enq(XIFU_XFIRDOTP, i, 5'(i), 5'(i), 32'h300 + i, 32'h0, 1'b0);
            step();
        end
        step();
        rst = 1'b1;
        exp_q.delete();
        inflight   = '0;
        commit_vec = '0;
        kill_vec   = '0;
        step();
        rst = 1'b0;
        err_exp = 1'b0;
        commit_vec[2:0] = 3'b111;
        repeat (5) step();
        commit_vec = '0;
        step();
        done = 1'b1;
    end

endmodule
